// File: rtl/bram_stream_reader.sv
// Read-side burst controller for the 3-stage pipelined simple dual-port BRAM.
// Optional `BRAM_STREAM_READER_LAST_EN adds an m_last end-of-burst marker.
module bram_stream_reader #(
  parameter int C_RAM_WIDTH = 64,
  parameter int C_RAM_DEPTH = 512,
  localparam int AW = $clog2(C_RAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  input  logic [AW:0]            num_words,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          rdAddr,
  output logic                   rden,
  input  logic [C_RAM_WIDTH-1:0] ram_dataout,
  output logic                   m_valid,
  input  logic                   m_ready,
`ifdef BRAM_STREAM_READER_LAST_EN
  output logic                   m_last,
`endif
  output logic [C_RAM_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   remaining;
  logic          v0, v1, v2;
  logic          stall, last_issue, flush_done, start_ok, start_zero;

  always_comb begin
    stall      = v2 & ~m_ready;
    rden       = ((state == S_READ) | ((state == S_FLUSH) & (v0 | v1))) & ~stall;
    last_issue = (state == S_READ) & rden & (remaining == (AW+1)'(1));
    flush_done = (state == S_FLUSH) & ~v0 & ~v1 & v2 & m_ready;
    start_ok   = (state == S_IDLE) & start & (num_words != '0);
    start_zero = (state == S_IDLE) & start & (num_words == '0);
    busy       = (state != S_IDLE);
    m_valid    = v2;
    m_data     = ram_dataout;

    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok)   state_nxt = S_READ;
      S_READ:  if (last_issue) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      rdAddr    <= '0;
      remaining <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= start_zero | flush_done;

      if (start_ok) begin
        rdAddr    <= start_addr;
        remaining <= num_words;
      end else if ((state == S_READ) && rden) begin
        rdAddr    <= (rdAddr == AW'(C_RAM_DEPTH - 1)) ? '0 : rdAddr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      // The valid bits shift exactly when the RAM pipeline shifts; otherwise
      // only an accepted output word can leave stage 2.
      if (rden) begin
        v0 <= (state == S_READ);
        v1 <= v0;
        v2 <= v1;
      end else if (v2 && m_ready) begin
        v2 <= 1'b0;
      end
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  logic l0, l1, l2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l0 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else if (rden) begin
      l0 <= last_issue;
      l1 <= l0;
      l2 <= l1;
    end else if (v2 && m_ready) begin
      l2 <= 1'b0;
    end
  end

  assign m_last = l2 & v2;
`endif

endmodule
